// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared types for the seven-segment display sharing logic.
//   digits_t    : 8 BCD/hex nibbles, nibble k drives digit k
//   blank_t     : per-digit blank mask, 1 = digit off
//   BLANK_ALL   : mask that turns every digit off
//   arb_state_t : arbiter FSM states
// -----------------------------------------------------------------------------
package sseg_pkg;

  typedef logic [31:0] digits_t;
  typedef logic [7:0]  blank_t;

  localparam blank_t BLANK_ALL = 8'hFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage : sseg_pkg

// File: rtl/sseg_arbiter_if.sv
// -----------------------------------------------------------------------------
// sseg_arbiter_if
// Bundle between the display clients and the display arbiter.
//   req          : per-client level request
//   req_digits   : client i digits in [32i+31:32i]
//   req_blank    : client i blank mask in [8i+7:8i]
//   grant        : one-hot current owner, zero when idle
//   grant_start  : one-cycle pulse when grant takes a new value
//   disp_digits  : registered digits towards the segment decoder
//   disp_blank   : registered blank mask towards the segment decoder
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sseg_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import sseg_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_digits;
  logic [NUM_REQ*8-1:0]  req_blank;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_start;
  digits_t               disp_digits;
  blank_t                disp_blank;

  modport master (
    output req, req_digits, req_blank,
    input  grant, grant_start, disp_digits, disp_blank
  );

  modport slave (
    input  req, req_digits, req_blank,
    output grant, grant_start, disp_digits, disp_blank
  );

endinterface : sseg_arbiter_if

// File: rtl/sseg_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first set bit of req
// searching upward from last+1 and wrapping modulo N.
//   req   : request mask
//   last  : index of the previous winner (search starts just above it)
//   pick  : index of the winner (0 when valid is low)
//   valid : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] pick,
  output logic            valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pick  = '0;
    valid = |req;
    // Walk from the farthest candidate to the nearest so the nearest set
    // bit after 'last' is the one that survives.
    for (int i = N; i >= 1; i--) begin
      if (req[IDXW'((int'(last) + i) % N)]) begin
        pick = IDXW'((int'(last) + i) % N);
      end
    end
  end

endmodule : rr_picker

// File: rtl/sseg_arbiter.sv
// -----------------------------------------------------------------------------
// sseg_arbiter
// Shares the 8-digit seven-segment display among NUM_REQ clients using
// round-robin arbitration with a minimum hold time. Requester 0 may preempt
// any other holder when PREEMPT0 = 1.
//   clk   : 40 MHz pixel clock
//   reset : asynchronous, active-high
//   bus   : sseg_arbiter_if.slave (requests/data in, grant/display out)
// Timing: req seen in IDLE at cycle N -> grant at N+1 -> disp_* at N+2.
// -----------------------------------------------------------------------------
module sseg_arbiter
  import sseg_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 40_000_000,
  parameter int PREEMPT0    = 1
) (
  input logic          clk,
  input logic          reset,
  sseg_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0]   RELOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);
  localparam logic [0:0]      ST_IDLE  = 1'(IDLE);
  localparam logic [0:0]      ST_HOLD  = 1'(HOLD);

  logic [0:0]         state;
  logic [IDXW-1:0]    last_grant;   // equals the holder index while granted
  logic [CW-1:0]      hold_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic               grant_start_q;
  digits_t            disp_digits_q;
  blank_t             disp_blank_q;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_valid;
  logic               holder_req;
  logic               preempt;

  // The holder is masked out so a hold-expiry switch always moves on; in
  // IDLE grant_q is zero and the full request vector is considered.
  assign cand       = bus.req & ~grant_q;
  assign holder_req = |(bus.req & grant_q);
  assign preempt    = (PREEMPT0 != 0) && bus.req[0] && (grant_q != '0) && !grant_q[0];

  rr_picker #(.N(NUM_REQ), .IDXW(IDXW)) u_picker (
    .req   (cand),
    .last  (last_grant),
    .pick  (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset is asynchronous; every register of the block is listed
    // here so a mid-grant reset clears the outputs without waiting for clk.
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= LAST_RST;
      hold_cnt      <= '0;
      grant_q       <= '0;
      grant_start_q <= 1'b0;
    end else begin
      grant_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q       <= pick_onehot;
            grant_start_q <= 1'b1;
            last_grant    <= pick_idx;
            hold_cnt      <= RELOAD;
            state         <= ST_HOLD;
          end
        end
        default: begin
          if (preempt) begin
            // Wins even over a simultaneous holder drop: no IDLE gap.
            grant_q       <= NUM_REQ'(1);
            grant_start_q <= 1'b1;
            last_grant    <= '0;
            hold_cnt      <= RELOAD;
          end else if (!holder_req) begin
            grant_q <= '0;
            state   <= ST_IDLE;
          end else if (hold_cnt == '0 && pick_valid) begin
            grant_q       <= pick_onehot;
            grant_start_q <= 1'b1;
            last_grant    <= pick_idx;
            hold_cnt      <= RELOAD;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Display path follows the registered owner, so live edits by the owner
  // reach the decoder one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_digits_q <= '0;
      disp_blank_q  <= BLANK_ALL;
    end else if (grant_q != '0) begin
      disp_digits_q <= bus.req_digits[{last_grant, 5'd0} +: 32];
      disp_blank_q  <= bus.req_blank[{last_grant, 3'd0} +: 8];
    end else begin
      disp_digits_q <= '0;
      disp_blank_q  <= BLANK_ALL;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_start = grant_start_q;
  assign bus.disp_digits = disp_digits_q;
  assign bus.disp_blank  = disp_blank_q;

endmodule : sseg_arbiter
